// File: rtl/register_bank.sv
// rtl/register_bank.sv - CPU register file with aliased PC, flags and registered read ports.
// Optional REG_BYPASS_EN: same-edge write/MOV/PC forwarding to the read ports.
module register_bank #(
  parameter int RegisterSize      = 32,
  parameter int AmountOfRegisters = 16,
  parameter int PCIndex           = 15,
  parameter int PCStep            = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              readRegister,
  output logic [RegisterSize-1:0] readValue,
  input  logic [3:0]              readRegisterB,
  output logic [RegisterSize-1:0] readValueB,
  input  logic                    writeEnable,
  input  logic [3:0]              writeRegister,
  input  logic [RegisterSize-1:0] writeValue,
  input  logic                    movEnable,
  input  logic [3:0]              MOVRegisterOrigin,
  input  logic [3:0]              MOVRegisterDestiny,
  input  logic                    pcIncrement,
  input  logic                    pcLoad,
  input  logic [RegisterSize-1:0] pcValue,
  output logic [RegisterSize-1:0] PC_Read,
  input  logic                    flagsWrite,
  input  logic [3:0]              flagsIn,
  output logic [3:0]              Flags
);

  localparam logic [3:0] PcIdx = 4'(PCIndex);

  logic [RegisterSize-1:0] regs_q [AmountOfRegisters];
  logic [RegisterSize-1:0] regs_d [AmountOfRegisters];
  logic [RegisterSize-1:0] pc_q, pc_d;
  logic [3:0]              flags_q, flags_d;
  logic [RegisterSize-1:0] read_a_q, read_a_d;
  logic [RegisterSize-1:0] read_b_q, read_b_d;

  logic                    wr_in_range, mov_dst_in_range, mov_org_in_range;
  logic                    rd_a_in_range, rd_b_in_range;
  logic                    wr_gpr, mov_gpr, wr_pc, mov_pc;
  logic [RegisterSize-1:0] mov_src;

  always_comb begin
    wr_in_range      = int'(writeRegister) < AmountOfRegisters;
    mov_dst_in_range = int'(MOVRegisterDestiny) < AmountOfRegisters;
    mov_org_in_range = int'(MOVRegisterOrigin) < AmountOfRegisters;
    rd_a_in_range    = int'(readRegister) < AmountOfRegisters;
    rd_b_in_range    = int'(readRegisterB) < AmountOfRegisters;
  end

  // MOV always sources the pre-edge state, so a same-edge write never leaks into it.
  always_comb begin
    mov_src = '0;
    if (MOVRegisterOrigin == PcIdx) begin
      mov_src = pc_q;
    end else if (mov_org_in_range) begin
      mov_src = regs_q[MOVRegisterOrigin];
    end
  end

  always_comb begin
    wr_pc   = writeEnable && (writeRegister == PcIdx);
    mov_pc  = movEnable && (MOVRegisterDestiny == PcIdx)
              && !(writeEnable && (writeRegister == MOVRegisterDestiny));
    wr_gpr  = writeEnable && (writeRegister != PcIdx) && wr_in_range;
    mov_gpr = movEnable && (MOVRegisterDestiny != PcIdx) && mov_dst_in_range
              && !(writeEnable && (writeRegister == MOVRegisterDestiny));
  end

  always_comb begin
    for (int i = 0; i < AmountOfRegisters; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (mov_gpr) begin
      regs_d[MOVRegisterDestiny] = mov_src;
    end
    if (wr_gpr) begin
      regs_d[writeRegister] = writeValue;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (pcLoad) begin
      pc_d = pcValue;
    end else if (wr_pc) begin
      pc_d = writeValue;
    end else if (mov_pc) begin
      pc_d = mov_src;
    end else if (pcIncrement) begin
      pc_d = pc_q + RegisterSize'(PCStep);
    end
  end

  always_comb begin
    flags_d = flags_q;
    if (flagsWrite) begin
      flags_d = flagsIn;
    end
  end

`ifdef REG_BYPASS_EN
  // Forward the post-edge state so a same-edge update is visible immediately.
  always_comb begin
    read_a_d = '0;
    read_b_d = '0;
    if (readRegister == PcIdx) begin
      read_a_d = pc_d;
    end else if (rd_a_in_range) begin
      read_a_d = regs_d[readRegister];
    end
    if (readRegisterB == PcIdx) begin
      read_b_d = pc_d;
    end else if (rd_b_in_range) begin
      read_b_d = regs_d[readRegisterB];
    end
  end
`else
  always_comb begin
    read_a_d = '0;
    read_b_d = '0;
    if (readRegister == PcIdx) begin
      read_a_d = pc_q;
    end else if (rd_a_in_range) begin
      read_a_d = regs_q[readRegister];
    end
    if (readRegisterB == PcIdx) begin
      read_b_d = pc_q;
    end else if (rd_b_in_range) begin
      read_b_d = regs_q[readRegisterB];
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < AmountOfRegisters; i++) begin
        regs_q[i] <= '0;
      end
      pc_q     <= '0;
      flags_q  <= '0;
      read_a_q <= '0;
      read_b_q <= '0;
    end else begin
      for (int i = 0; i < AmountOfRegisters; i++) begin
        regs_q[i] <= regs_d[i];
      end
      pc_q     <= pc_d;
      flags_q  <= flags_d;
      read_a_q <= read_a_d;
      read_b_q <= read_b_d;
    end
  end

  assign readValue  = read_a_q;
  assign readValueB = read_b_q;
  assign PC_Read    = pc_q;
  assign Flags      = flags_q;

endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - directed self-checking bench for register_bank.
module tb_register_bank;

  logic        clk;
  logic        reset;
  logic [3:0]  readRegister, readRegisterB;
  logic [31:0] readValue, readValueB;
  logic        writeEnable;
  logic [3:0]  writeRegister;
  logic [31:0] writeValue;
  logic        movEnable;
  logic [3:0]  MOVRegisterOrigin, MOVRegisterDestiny;
  logic        pcIncrement, pcLoad;
  logic [31:0] pcValue, PC_Read;
  logic        flagsWrite;
  logic [3:0]  flagsIn, Flags;

  int n_checks = 0;
  int n_fail   = 0;

  register_bank dut (
    .clk               (clk),
    .reset             (reset),
    .readRegister      (readRegister),
    .readValue         (readValue),
    .readRegisterB     (readRegisterB),
    .readValueB        (readValueB),
    .writeEnable       (writeEnable),
    .writeRegister     (writeRegister),
    .writeValue        (writeValue),
    .movEnable         (movEnable),
    .MOVRegisterOrigin (MOVRegisterOrigin),
    .MOVRegisterDestiny(MOVRegisterDestiny),
    .pcIncrement       (pcIncrement),
    .pcLoad            (pcLoad),
    .pcValue           (pcValue),
    .PC_Read           (PC_Read),
    .flagsWrite        (flagsWrite),
    .flagsIn           (flagsIn),
    .Flags             (Flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    writeEnable = 1'b0; movEnable = 1'b0; pcIncrement = 1'b0; pcLoad = 1'b0;
    flagsWrite = 1'b0; writeRegister = 4'd0; writeValue = '0;
    MOVRegisterOrigin = 4'd0; MOVRegisterDestiny = 4'd0; pcValue = '0; flagsIn = 4'd0;
  endtask

  task automatic wr(input logic [3:0] idx, input logic [31:0] val);
    writeEnable = 1'b1; writeRegister = idx; writeValue = val;
    step();
    idle();
  endtask

  initial begin
    reset = 1'b0;
    readRegister = 4'd0; readRegisterB = 4'd0;
    idle();
    #1;
    check("reset_readValue", readValue, 32'h0);
    check("reset_pc", PC_Read, 32'h0);
    check("reset_flags", {28'd0, Flags}, 32'h0);
    step();
    reset = 1'b1;

    // Populate state, then pull reset mid-run
    wr(4'd3, 32'h55);
    pcLoad = 1'b1; pcValue = 32'h100; flagsWrite = 1'b1; flagsIn = 4'b0101;
    step(); idle();
    readRegister = 4'd3;
    step();
    check("pre_reset_r3", readValue, 32'h55);
    check("pre_reset_pc", PC_Read, 32'h100);
    reset = 1'b0;
    #1;
    check("async_reset_readValue", readValue, 32'h0);
    check("async_reset_pc", PC_Read, 32'h0);
    check("async_reset_flags", {28'd0, Flags}, 32'h0);
    step();
    reset = 1'b1;
    step();
    check("post_reset_r3", readValue, 32'h0);

    // Basic write then read, port B on an unwritten register
    wr(4'd5, 32'h0000_00A0);
    readRegister = 4'd5; readRegisterB = 4'd6;
    step();
    check("read_r5", readValue, 32'h0000_00A0);
    check("read_b_r6", readValueB, 32'h0);

    // Write/MOV conflict on the same destination: write wins
    wr(4'd2, 32'h7);
    wr(4'd4, 32'h9);
    movEnable = 1'b1; MOVRegisterOrigin = 4'd2; MOVRegisterDestiny = 4'd4;
    writeEnable = 1'b1; writeRegister = 4'd4; writeValue = 32'h11;
    step(); idle();
    readRegister = 4'd4;
    step();
    check("conflict_same_dst_r4", readValue, 32'h11);

    // Different destinations: both commit
    movEnable = 1'b1; MOVRegisterOrigin = 4'd2; MOVRegisterDestiny = 4'd4;
    writeEnable = 1'b1; writeRegister = 4'd1; writeValue = 32'h11;
    step(); idle();
    readRegister = 4'd4; readRegisterB = 4'd1;
    step();
    check("conflict_diff_dst_r4", readValue, 32'h7);
    check("conflict_diff_dst_r1", readValueB, 32'h11);

    // MOV with origin == destination leaves the register alone
    movEnable = 1'b1; MOVRegisterOrigin = 4'd4; MOVRegisterDestiny = 4'd4;
    step(); idle();
    step();
    check("mov_self_r4", readValue, 32'h7);

    // PC wrap and priority
    pcLoad = 1'b1; pcValue = 32'hFFFF_FFFC;
    step(); idle();
    check("pc_load_top", PC_Read, 32'hFFFF_FFFC);
    pcIncrement = 1'b1;
    step(); idle();
    check("pc_wrap", PC_Read, 32'h0);
    pcLoad = 1'b1; pcValue = 32'h40; pcIncrement = 1'b1;
    writeEnable = 1'b1; writeRegister = 4'd15; writeValue = 32'h80;
    step(); idle();
    check("pc_load_priority", PC_Read, 32'h40);
    pcIncrement = 1'b1; writeEnable = 1'b1; writeRegister = 4'd15; writeValue = 32'h90;
    step(); idle();
    check("pc_write_over_inc", PC_Read, 32'h90);
    pcIncrement = 1'b1; movEnable = 1'b1; MOVRegisterOrigin = 4'd2; MOVRegisterDestiny = 4'd15;
    step(); idle();
    check("pc_mov_over_inc", PC_Read, 32'h7);

    // PC read through port A alongside an increment
    readRegister = 4'd15; pcIncrement = 1'b1;
    step(); idle();
    check("pc_inc_plain", PC_Read, 32'hB);
`ifdef REG_BYPASS_EN
    check("read_pc_same_edge", readValue, 32'hB);
`else
    check("read_pc_same_edge", readValue, 32'h7);
`endif

    // MOV from the PC copies the pre-edge PC
    movEnable = 1'b1; MOVRegisterOrigin = 4'd15; MOVRegisterDestiny = 4'd9; pcIncrement = 1'b1;
    step(); idle();
    readRegister = 4'd9;
    step();
    check("mov_from_pc_r9", readValue, 32'hB);
    check("pc_after_mov_inc", PC_Read, 32'hF);

    // Same-edge write and read of R8
    readRegister = 4'd8;
    writeEnable = 1'b1; writeRegister = 4'd8; writeValue = 32'h33;
    step(); idle();
`ifdef REG_BYPASS_EN
    check("rbw_r8", readValue, 32'h33);
`else
    check("rbw_r8", readValue, 32'h0);
`endif
    step();
    check("r8_after", readValue, 32'h33);

    // Flags latch only on flagsWrite
    flagsWrite = 1'b1; flagsIn = 4'b0110;
    step(); idle();
    check("flags_write", {28'd0, Flags}, 32'h6);
    flagsIn = 4'b1111;
    step(); idle();
    check("flags_hold", {28'd0, Flags}, 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
